// File: rtl/twophase_monitor_pkg.sv
// Shared definitions for the two-phase clock monitor: state encoding,
// default parameters and error-flag indices.
package twophase_monitor_pkg;

  localparam int CNT_W_DEF       = 8;
  localparam int MIN_GAP_DEF     = 2;
  localparam int TIMEOUT_DEF     = 200;
  localparam int LOCK_CYCLES_DEF = 4;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_PH1   = 3'd1,
    ST_GAP_B = 3'd2,
    ST_PH2   = 3'd3,
    ST_GAP_A = 3'd4
  } state_t;

  localparam int ERR_OVERLAP_IDX = 0;
  localparam int ERR_GAP_IDX     = 1;
  localparam int ERR_ORDER_IDX   = 2;
  localparam int ERR_STUCK_IDX   = 3;
  localparam int ERR_NUM         = 4;

  // Recovered clock is high from PHI1 rise until PHI2 rise.
  function automatic logic clk_rec_level(input state_t st);
    return (st == ST_PH1) || (st == ST_GAP_B);
  endfunction

endpackage

// File: rtl/twophase_monitor_if.sv
// Phase inputs, error clear and all monitor results, grouped for the
// stimulus side (master) and the monitor itself (slave).
interface twophase_monitor_if #(
  parameter int CNT_W = twophase_monitor_pkg::CNT_W_DEF
);
  logic             i_phi1;
  logic             i_phi2;
  logic             i_clr_err;
  logic             o_clk_rec;
  logic             o_locked;
  logic             o_err_overlap;
  logic             o_err_gap;
  logic             o_err_order;
  logic             o_err_stuck;
  logic [CNT_W-1:0] o_p1_width;
  logic [CNT_W-1:0] o_gap_width;
  logic             o_width_valid;

  modport master (
    output i_phi1, i_phi2, i_clr_err,
    input  o_clk_rec, o_locked, o_err_overlap, o_err_gap, o_err_order,
           o_err_stuck, o_p1_width, o_gap_width, o_width_valid
  );

  modport slave (
    input  i_phi1, i_phi2, i_clr_err,
    output o_clk_rec, o_locked, o_err_overlap, o_err_gap, o_err_order,
           o_err_stuck, o_p1_width, o_gap_width, o_width_valid
  );
endinterface

// File: rtl/twophase_monitor_sync2.sv
// Two-flop synchronizer bringing one asynchronous phase into the
// sampling clock domain.
module twophase_monitor_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_q;

  // NOTE: non-blocking assignments keep both flops sampling the pre-edge
  // values, so this stays a true two-stage shift rather than one wire.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;
endmodule

// File: rtl/twophase_monitor.sv
// Two-phase clock checker: tracks the PHI1/PHI2 sequence, measures widths,
// flags overlap/gap/order/stuck faults and recovers a single-phase clock.
module twophase_monitor
  import twophase_monitor_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MIN_GAP     = MIN_GAP_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic                 i_clk_in,
  input  logic                 i_rst,
  twophase_monitor_if.slave    bus
);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
  localparam logic [CNT_W-1:0]  MIN_GAP_C  = CNT_W'(MIN_GAP);
  localparam logic [CNT_W-1:0]  STUCK_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX   = LOCK_W'(LOCK_CYCLES);

  logic w_s1;
  logic w_s2;

  twophase_monitor_sync2 u_sync_phi1 (
    .i_clk (i_clk_in),
    .i_rst (i_rst),
    .i_d   (bus.i_phi1),
    .o_q   (w_s1)
  );

  twophase_monitor_sync2 u_sync_phi2 (
    .i_clk (i_clk_in),
    .i_rst (i_rst),
    .i_d   (bus.i_phi2),
    .o_q   (w_s2)
  );

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_stuck_cnt;
  logic [LOCK_W-1:0]   r_lock_cnt;
  logic [LOCK_W-1:0]   w_lock_next;
  logic [ERR_NUM-1:0]  r_err;
  logic [ERR_NUM-1:0]  w_err_set;
  logic                w_error;
  logic                w_gap_ok;
  logic                w_good_period;
  logic                w_latch_p1;
  logic                w_latch_gap;
  logic                w_restart;
  logic                r_clk_rec;
  logic                r_locked;
  logic                r_width_valid;
  logic [CNT_W-1:0]    r_p1_width;
  logic [CNT_W-1:0]    r_gap_width;

  // NOTE: every variable gets a default before the case so that no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_err_set     = '0;
    w_good_period = 1'b0;
    w_latch_p1    = 1'b0;
    w_gap_ok      = (r_cnt >= MIN_GAP_C);

    if (w_s1 && w_s2) begin
      w_err_set[ERR_OVERLAP_IDX] = 1'b1;
    end else begin
      unique case (r_state)
        ST_SYNC: if (w_s1) w_next_state = ST_PH1;
        ST_PH1: begin
          if (w_s2) begin
            w_err_set[ERR_GAP_IDX] = 1'b1;
          end else if (!w_s1) begin
            w_next_state = ST_GAP_B;
            w_latch_p1   = 1'b1;
          end
        end
        ST_GAP_B: begin
          if (w_s2) begin
            if (w_gap_ok) w_next_state = ST_PH2;
            else          w_err_set[ERR_GAP_IDX] = 1'b1;
          end else if (w_s1) begin
            w_err_set[ERR_ORDER_IDX] = 1'b1;
          end
        end
        ST_PH2: begin
          if (w_s1)       w_err_set[ERR_GAP_IDX] = 1'b1;
          else if (!w_s2) w_next_state = ST_GAP_A;
        end
        ST_GAP_A: begin
          if (w_s1) begin
            if (w_gap_ok) begin
              w_next_state  = ST_PH1;
              w_good_period = 1'b1;
            end else begin
              w_err_set[ERR_GAP_IDX] = 1'b1;
            end
          end else if (w_s2) begin
            w_err_set[ERR_ORDER_IDX] = 1'b1;
          end
        end
        default: w_next_state = ST_SYNC;
      endcase
    end

    // Stuck only counts when nothing else would move the state this cycle.
    if ((w_err_set == '0) && (w_next_state == r_state) && (r_stuck_cnt == STUCK_LAST))
      w_err_set[ERR_STUCK_IDX] = 1'b1;

    w_error = |w_err_set;
    if (w_error) w_next_state = ST_SYNC;

    w_restart   = w_error || (w_next_state != r_state);
    w_latch_gap = ((r_state == ST_GAP_A) || (r_state == ST_GAP_B)) &&
                  (w_next_state != r_state);

    if (w_error)
      w_lock_next = '0;
    else if (w_good_period && (r_lock_cnt != LOCK_MAX))
      w_lock_next = r_lock_cnt + 1'b1;
    else
      w_lock_next = r_lock_cnt;
  end

  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_SYNC;
      r_cnt         <= CNT_W'(1);
      r_stuck_cnt   <= '0;
      r_lock_cnt    <= '0;
      r_err         <= '0;
      r_clk_rec     <= 1'b0;
      r_locked      <= 1'b0;
      r_width_valid <= 1'b0;
      r_p1_width    <= '0;
      r_gap_width   <= '0;
    end else begin
      r_state <= w_next_state;

      if (w_restart) begin
        r_cnt       <= CNT_W'(1);
        r_stuck_cnt <= '0;
      end else begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        r_stuck_cnt <= r_stuck_cnt + 1'b1;
      end

      if (w_latch_p1)  r_p1_width  <= r_cnt;
      if (w_latch_gap) r_gap_width <= r_cnt;
      r_width_valid <= w_latch_p1 || w_latch_gap;

      // A new error wins over a clear arriving in the same cycle.
      r_err      <= (r_err & ~{ERR_NUM{bus.i_clr_err}}) | w_err_set;
      r_lock_cnt <= w_lock_next;
      r_locked   <= (w_lock_next == LOCK_MAX);
      r_clk_rec  <= clk_rec_level(w_next_state);
    end
  end

  assign bus.o_clk_rec     = r_clk_rec;
  assign bus.o_locked      = r_locked;
  assign bus.o_err_overlap = r_err[ERR_OVERLAP_IDX];
  assign bus.o_err_gap     = r_err[ERR_GAP_IDX];
  assign bus.o_err_order   = r_err[ERR_ORDER_IDX];
  assign bus.o_err_stuck   = r_err[ERR_STUCK_IDX];
  assign bus.o_p1_width    = r_p1_width;
  assign bus.o_gap_width   = r_gap_width;
  assign bus.o_width_valid = r_width_valid;
endmodule

// File: tb/tb_twophase_monitor.sv
// Directed bench for twophase_monitor: a run-length model of the phase
// stream is compared against the DUT every cycle, plus literal spot checks.
module tb_twophase_monitor;
  import twophase_monitor_pkg::*;

  localparam int CNT_W       = 8;
  localparam int MIN_GAP     = 2;
  localparam int TIMEOUT     = 200;
  localparam int LOCK_CYCLES = 4;
  localparam int OUT_W       = 7 + 2 * CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b0;

  twophase_monitor_if #(.CNT_W(CNT_W)) bus ();

  twophase_monitor #(
    .CNT_W       (CNT_W),
    .MIN_GAP     (MIN_GAP),
    .TIMEOUT     (TIMEOUT),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .i_clk_in (clk),
    .i_rst    (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] dut_out();
    return {bus.o_clk_rec, bus.o_locked, bus.o_err_stuck, bus.o_err_order,
            bus.o_err_gap, bus.o_err_overlap, bus.o_width_valid,
            bus.o_p1_width, bus.o_gap_width};
  endfunction

  function automatic logic [3:0] dut_errs();
    return {bus.o_err_stuck, bus.o_err_order, bus.o_err_gap, bus.o_err_overlap};
  endfunction

  // Model: the synchronized stream is the pin value two edges earlier. Widths
  // are run lengths of a sample pattern; the monitor position is derived from
  // the last legal phase and the current pattern instead of a state variable.
  logic [1:0] m_hist0 = 2'b00, m_hist1 = 2'b00, m_prev = 2'b00;
  bit         m_sync = 1'b1;
  int         m_last = 0, m_run = 0, m_idle = 0, m_lock = 0;
  bit   [3:0] m_err = 4'h0;
  int         m_p1w = 0, m_gapw = 0;
  bit         m_valid = 1'b0, m_locked = 1'b0, m_clk_rec = 1'b0;

  task automatic model_reset();
    m_hist0 = 2'b00; m_hist1 = 2'b00; m_prev = 2'b00;
    m_sync = 1'b1; m_last = 0; m_run = 0; m_idle = 0; m_lock = 0;
    m_err = 4'h0; m_p1w = 0; m_gapw = 0;
    m_valid = 1'b0; m_locked = 1'b0; m_clk_rec = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] pin, input logic clr);
    logic [1:0] p;
    bit   [3:0] set;
    int         phase;
    p = m_hist1;
    m_hist1 = m_hist0;
    m_hist0 = pin;
    set = 4'h0;
    m_valid = 1'b0;
    if (p == 2'b11) begin
      set[ERR_OVERLAP_IDX] = 1'b1;
      if (!m_sync && m_prev == 2'b00) begin m_gapw = m_run; m_valid = 1'b1; end
    end else if (m_sync) begin
      if (p == 2'b10) begin m_sync = 1'b0; m_last = 1; m_run = 1; end
      else if (m_idle == TIMEOUT - 1) set[ERR_STUCK_IDX] = 1'b1;
      else m_idle++;
    end else if (p == m_prev) begin
      if (m_run == TIMEOUT) begin
        set[ERR_STUCK_IDX] = 1'b1;
        if (p == 2'b00) begin m_gapw = m_run; m_valid = 1'b1; end
      end else begin
        m_run++;
      end
    end else begin
      if (m_prev == 2'b00) begin
        m_gapw = m_run; m_valid = 1'b1;
        phase = (p == 2'b10) ? 1 : 2;
        if (phase == m_last)      set[ERR_ORDER_IDX] = 1'b1;
        else if (m_run < MIN_GAP) set[ERR_GAP_IDX] = 1'b1;
        else begin
          m_last = phase;
          if (phase == 1 && m_lock < LOCK_CYCLES) m_lock++;
        end
      end else if (p == 2'b00) begin
        if (m_prev == 2'b10) begin m_p1w = m_run; m_valid = 1'b1; end
      end else begin
        set[ERR_GAP_IDX] = 1'b1;
      end
      m_run = 1;
    end
    m_prev = p;
    if (set != 4'h0) begin m_sync = 1'b1; m_idle = 0; m_lock = 0; end
    m_err     = (m_err & ~{4{clr}}) | set;
    m_locked  = (m_lock == LOCK_CYCLES);
    m_clk_rec = !m_sync && (m_last == 1);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) model_reset();
    else     model_step({bus.i_phi1, bus.i_phi2}, bus.i_clr_err);
  end

  function automatic logic [OUT_W-1:0] model_out();
    logic [CNT_W-1:0] p1w;
    logic [CNT_W-1:0] gw;
    p1w = m_p1w[CNT_W-1:0];
    gw  = m_gapw[CNT_W-1:0];
    return {m_clk_rec, m_locked, m_err[3], m_err[2], m_err[1], m_err[0], m_valid, p1w, gw};
  endfunction

  initial forever begin
    @(negedge clk);
    if (!rst) check("cycle_outputs", dut_out(), model_out());
  end

  task automatic pins(input logic [1:0] p, input int n);
    bus.i_phi1 = p[1];
    bus.i_phi2 = p[0];
    repeat (n) @(negedge clk);
  endtask

  task automatic period(input int hi, input int gap);
    pins(2'b10, hi); pins(2'b00, gap); pins(2'b01, hi); pins(2'b00, gap);
  endtask

  task automatic clr_pulse();
    bus.i_clr_err = 1'b1;
    @(negedge clk);
    bus.i_clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bus.i_phi1 = 1'b0; bus.i_phi2 = 1'b0; bus.i_clr_err = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", dut_out(), '0);
    rst = 1'b0;

    // Clean pair; lock needs four GAP_A->PH1 periods, i.e. the 5th PHI1 rise.
    repeat (4) period(10, 3);
    check("no_lock_after_4", bus.o_locked, 1'b0);
    pins(2'b10, 2);
    check("clk_rec_lag_2", bus.o_clk_rec, 1'b0);
    pins(2'b10, 1);
    check("clk_rec_lag_3", bus.o_clk_rec, 1'b1);
    check("lock_5th_rise", bus.o_locked, 1'b1);
    pins(2'b10, 7); pins(2'b00, 3); pins(2'b01, 10); pins(2'b00, 3);
    check("p1_width_clean", bus.o_p1_width, 10);
    check("gap_width_clean", bus.o_gap_width, 3);
    check("model_p1_width", m_p1w, 10);
    check("clean_flags", dut_errs(), 4'h0);

    // Overlap, then relock while the overlap flag stays sticky.
    pins(2'b10, 4); pins(2'b11, 2); pins(2'b10, 4);
    check("overlap_flag", bus.o_err_overlap, 1'b1);
    check("overlap_unlock", bus.o_locked, 1'b0);
    pins(2'b00, 3); pins(2'b01, 10); pins(2'b00, 3);
    repeat (5) period(10, 3);
    check("relock", bus.o_locked, 1'b1);
    check("overlap_sticky", bus.o_err_overlap, 1'b1);

    // Gap of one cycle fails, gap of two passes.
    pins(2'b10, 10); pins(2'b00, 1); pins(2'b01, 10); pins(2'b00, 3);
    check("gap1_flag", bus.o_err_gap, 1'b1);
    check("gap1_width", bus.o_gap_width, 1);
    check("model_gap1", m_gapw, 1);
    clr_pulse();
    check("clr_all", dut_errs(), 4'h0);
    pins(2'b10, 10); pins(2'b00, 2); pins(2'b01, 10); pins(2'b00, 3);
    check("gap2_no_flag", bus.o_err_gap, 1'b0);
    check("gap2_width", bus.o_gap_width, 2);

    // PHI1 twice in a row.
    pins(2'b10, 5); pins(2'b00, 3); pins(2'b10, 5); pins(2'b00, 4);
    check("order_flag", bus.o_err_order, 1'b1);
    check("order_unlock", bus.o_locked, 1'b0);
    clr_pulse();
    check("order_clr", bus.o_err_order, 1'b0);
    pins(2'b01, 5); pins(2'b00, 3);

    // PHI1 stuck high: flag appears 203 cycles after the pin rises.
    pins(2'b10, 200);
    check("stuck_not_yet", bus.o_err_stuck, 1'b0);
    pins(2'b10, 5);
    check("stuck_flag", bus.o_err_stuck, 1'b1);
    check("stuck_unlock", bus.o_locked, 1'b0);
    pins(2'b10, 45);

    // Reset in the middle of PH2, then restart straight from PHI2 to PHI1.
    pins(2'b00, 3); pins(2'b01, 5);
    check("in_ph2_clk_rec", bus.o_clk_rec, 1'b0);
    #2 rst = 1'b1;
    #1 check("reset_mid_ph2", dut_out(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pins(2'b01, 3); pins(2'b10, 10);
    check("after_rst_no_gap", bus.o_err_gap, 1'b0);
    check("after_rst_clk_rec", bus.o_clk_rec, 1'b1);
    pins(2'b00, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
